memory_cycle: RTL and testbench

//  Memory stage of the 16-bit pipeline. Sits after the execute stage.

---
 rtl/memory_cycle_if.sv | 44 ++++
 rtl/memory_cycle.sv | 201 ++++++++++++++++++++
 tb/tb_memory_cycle.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_cycle_if.sv
// Bus between the execute stage (master) and the memory stage (slave).
// Carries the execute result, the stall/flush handshake back upstream,
// the writeback result and the forwarding path.
interface memory_cycle_if #(
    parameter int DATA_W = 16
);
    // execute -> memory
    logic              valid_in;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] storedata;
    logic [3:0]        rdin;
    logic [DATA_W-1:0] newpc;
    logic              zero;
    logic              pos;
    logic              memread;
    logic              memwrite;
    logic              regwrite_in;
    logic [1:0]        branch;
    // memory -> upstream / writeback
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] pc_target;
    logic [DATA_W-1:0] wbdata;
    logic [3:0]        rdout;
    logic              regwrite_out;
    logic              valid_out;
    logic              fwd_valid;
    logic [3:0]        fwd_rd;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output valid_in, aluout, storedata, rdin, newpc, zero, pos,
               memread, memwrite, regwrite_in, branch,
        input  stall, flush, pc_target, wbdata, rdout, regwrite_out,
               valid_out, fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  valid_in, aluout, storedata, rdin, newpc, zero, pos,
               memread, memwrite, regwrite_in, branch,
        output stall, flush, pc_target, wbdata, rdout, regwrite_out,
               valid_out, fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/memory_cycle.sv
// Memory stage of the 16-bit pipeline: resolves branches, performs
// data-memory loads/stores on an internal word array with MEM_WAIT wait
// states, and registers the result for writeback.
// Optional feature macro: MEMORY_CYCLE_FWD_EN (drives the fwd_* bypass
// outputs from the registered writeback result; tied to 0 otherwise).
module memory_cycle #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int MEM_WAIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    memory_cycle_if.slave bus
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam int CNT_W = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] aluout_q, aluout_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        rd_q, rd_d;
    logic              is_store_q, is_store_d;
    logic              regwr_q, regwr_d;

    logic [DATA_W-1:0] wbdata_q, wbdata_d;
    logic [3:0]        rdout_q, rdout_d;
    logic              regwrite_out_q, regwrite_out_d;
    logic              valid_out_q, valid_out_d;
    logic              flush_q, flush_d;
    logic [DATA_W-1:0] pc_target_q, pc_target_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    logic              taken;
    logic              mem_op;
    logic              stall_c;

    // Branch resolution on the incoming execute result.
    always_comb begin
        case (bus.branch)
            2'b01:   taken = bus.zero;
            2'b10:   taken = bus.pos;
            2'b11:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // A taken branch squashes any memory access carried by the same op.
    assign mem_op    = (bus.memread | bus.memwrite) & ~taken;
    assign mem_raddr = (state_q == BUSY) ? aluout_q[ADDR_W-1:0] : bus.aluout[ADDR_W-1:0];
    assign mem_rdata = mem_q[mem_raddr];

    // Next-state, memory-port and registered-output logic for the IDLE/BUSY FSM.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        aluout_d       = aluout_q;
        data_d         = data_q;
        rd_d           = rd_q;
        is_store_d     = is_store_q;
        regwr_d        = regwr_q;
        wbdata_d       = wbdata_q;
        rdout_d        = rdout_q;
        pc_target_d    = pc_target_q;
        regwrite_out_d = 1'b0;
        valid_out_d    = 1'b0;
        flush_d        = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = aluout_q[ADDR_W-1:0];
        mem_wdata      = data_q;
        stall_c        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    if (taken) begin
                        flush_d     = 1'b1;
                        pc_target_d = bus.newpc;
                    end
                    if (mem_op && MEM_WAIT != 0) begin
                        state_d    = BUSY;
                        cnt_d      = CNT_W'(MEM_WAIT);
                        aluout_d   = bus.aluout;
                        data_d     = bus.storedata;
                        rd_d       = bus.rdin;
                        is_store_d = bus.memwrite;
                        regwr_d    = bus.regwrite_in;
                        stall_c    = 1'b1;
                    end else begin
                        valid_out_d = 1'b1;
                        rdout_d     = bus.rdin;
                        if (mem_op && bus.memwrite) begin
                            mem_we         = 1'b1;
                            mem_waddr      = bus.aluout[ADDR_W-1:0];
                            mem_wdata      = bus.storedata;
                            wbdata_d       = bus.aluout;
                            regwrite_out_d = 1'b0;
                        end else if (mem_op) begin
                            wbdata_d       = mem_rdata;
                            regwrite_out_d = bus.regwrite_in;
                        end else begin
                            wbdata_d       = bus.aluout;
                            regwrite_out_d = bus.regwrite_in;
                        end
                    end
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    // Last wait cycle: access happens now, result visible next cycle.
                    state_d     = IDLE;
                    cnt_d       = '0;
                    valid_out_d = 1'b1;
                    rdout_d     = rd_q;
                    if (is_store_q) begin
                        mem_we         = 1'b1;
                        wbdata_d       = aluout_q;
                        regwrite_out_d = 1'b0;
                    end else begin
                        wbdata_d       = mem_rdata;
                        regwrite_out_d = regwr_q;
                    end
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    // Pipeline state and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            aluout_q       <= '0;
            data_q         <= '0;
            rd_q           <= '0;
            is_store_q     <= 1'b0;
            regwr_q        <= 1'b0;
            wbdata_q       <= '0;
            rdout_q        <= '0;
            regwrite_out_q <= 1'b0;
            valid_out_q    <= 1'b0;
            flush_q        <= 1'b0;
            pc_target_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            aluout_q       <= aluout_d;
            data_q         <= data_d;
            rd_q           <= rd_d;
            is_store_q     <= is_store_d;
            regwr_q        <= regwr_d;
            wbdata_q       <= wbdata_d;
            rdout_q        <= rdout_d;
            regwrite_out_q <= regwrite_out_d;
            valid_out_q    <= valid_out_d;
            flush_q        <= flush_d;
            pc_target_q    <= pc_target_d;
        end
    end

    // Data-memory array: never cleared; a store pending at reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.stall        = stall_c & ~rst;
    assign bus.flush        = flush_q;
    assign bus.pc_target    = pc_target_q;
    assign bus.wbdata       = wbdata_q;
    assign bus.rdout        = rdout_q;
    assign bus.regwrite_out = regwrite_out_q;
    assign bus.valid_out    = valid_out_q;

`ifdef MEMORY_CYCLE_FWD_EN
    assign bus.fwd_valid = valid_out_q & regwrite_out_q;
    assign bus.fwd_rd    = rdout_q;
    assign bus.fwd_data  = wbdata_q;
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_rd    = '0;
    assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_memory_cycle.sv
// Directed testbench for memory_cycle (DATA_W=16, ADDR_W=8, MEM_WAIT=2).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_memory_cycle;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    memory_cycle_if #(.DATA_W(16)) bus ();

    memory_cycle #(
        .DATA_W  (16),
        .ADDR_W  (8),
        .MEM_WAIT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_in    = 1'b0;
        bus.aluout      = '0;
        bus.storedata   = '0;
        bus.rdin        = '0;
        bus.newpc       = '0;
        bus.zero        = 1'b0;
        bus.pos         = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.regwrite_in = 1'b0;
        bus.branch      = 2'b00;
    endtask

    // Issue a store and wait through its full MEM_WAIT+1 latency.
    task automatic do_store(input logic [15:0] addr, input logic [15:0] data);
        idle_inputs();
        bus.valid_in  = 1'b1;
        bus.memwrite  = 1'b1;
        bus.aluout    = addr;
        bus.storedata = data;
        tick(); tick(); tick();
        idle_inputs();
    endtask

    // Issue a load; on return the result is on wbdata/valid_out.
    task automatic do_load(input logic [15:0] addr, input logic [3:0] rd);
        idle_inputs();
        bus.valid_in    = 1'b1;
        bus.memread     = 1'b1;
        bus.regwrite_in = 1'b1;
        bus.aluout      = addr;
        bus.rdin        = rd;
        tick(); tick(); tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (bus.stall !== 1'b0) begin n_fails++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        n_checks++; if (bus.flush !== 1'b0) begin n_fails++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fails++; $display("FAIL reset_valid_out: got %b want 0", bus.valid_out); end
        n_checks++; if (bus.regwrite_out !== 1'b0) begin n_fails++; $display("FAIL reset_regwrite_out: got %b want 0", bus.regwrite_out); end
        n_checks++; if (bus.wbdata !== 16'h0000) begin n_fails++; $display("FAIL reset_wbdata: got %h want 0000", bus.wbdata); end
        n_checks++; if (bus.rdout !== 4'h0) begin n_fails++; $display("FAIL reset_rdout: got %h want 0", bus.rdout); end
        n_checks++; if (bus.pc_target !== 16'h0000) begin n_fails++; $display("FAIL reset_pc_target: got %h want 0000", bus.pc_target); end
        n_checks++; if (bus.fwd_valid !== 1'b0) begin n_fails++; $display("FAIL reset_fwd_valid: got %b want 0", bus.fwd_valid); end
        n_checks++; if (bus.fwd_data !== 16'h0000) begin n_fails++; $display("FAIL reset_fwd_data: got %h want 0000", bus.fwd_data); end
        rst = 1'b0;
    endtask

    task automatic test_alu_pass();
        idle_inputs();
        bus.valid_in    = 1'b1;
        bus.aluout      = 16'h1234;
        bus.rdin        = 4'd3;
        bus.regwrite_in = 1'b1;
        #1;
        n_checks++; if (bus.stall !== 1'b0) begin n_fails++; $display("FAIL alu_stall: got %b want 0", bus.stall); end
        tick();
        idle_inputs();
        n_checks++; if (bus.valid_out !== 1'b1) begin n_fails++; $display("FAIL alu_valid_out: got %b want 1", bus.valid_out); end
        n_checks++; if (bus.wbdata !== 16'h1234) begin n_fails++; $display("FAIL alu_wbdata: got %h want 1234", bus.wbdata); end
        n_checks++; if (bus.rdout !== 4'd3) begin n_fails++; $display("FAIL alu_rdout: got %0d want 3", bus.rdout); end
        n_checks++; if (bus.regwrite_out !== 1'b1) begin n_fails++; $display("FAIL alu_regwrite_out: got %b want 1", bus.regwrite_out); end
        tick();
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fails++; $display("FAIL idle_valid_out: got %b want 0", bus.valid_out); end
        n_checks++; if (bus.regwrite_out !== 1'b0) begin n_fails++; $display("FAIL idle_regwrite_out: got %b want 0", bus.regwrite_out); end
        n_checks++; if (bus.wbdata !== 16'h1234) begin n_fails++; $display("FAIL idle_wbdata_hold: got %h want 1234", bus.wbdata); end
        n_checks++; if (bus.rdout !== 4'd3) begin n_fails++; $display("FAIL idle_rdout_hold: got %0d want 3", bus.rdout); end
    endtask

    task automatic test_back_to_back();
        // store BEEF at 0x0105 (word 0x05), held while stalled
        idle_inputs();
        bus.valid_in    = 1'b1;
        bus.memwrite    = 1'b1;
        bus.aluout      = 16'h0105;
        bus.storedata   = 16'hBEEF;
        bus.rdin        = 4'd2;
        bus.regwrite_in = 1'b1;
        #1;
        n_checks++; if (bus.stall !== 1'b1) begin n_fails++; $display("FAIL st_stall_c0: got %b want 1", bus.stall); end
        tick();
        n_checks++; if (bus.stall !== 1'b1) begin n_fails++; $display("FAIL st_stall_c1: got %b want 1", bus.stall); end
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fails++; $display("FAIL st_valid_c1: got %b want 0", bus.valid_out); end
        tick();
        n_checks++; if (bus.stall !== 1'b0) begin n_fails++; $display("FAIL st_stall_c2: got %b want 0", bus.stall); end
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fails++; $display("FAIL st_valid_c2: got %b want 0", bus.valid_out); end
        tick();
        n_checks++; if (bus.valid_out !== 1'b1) begin n_fails++; $display("FAIL st_valid_c3: got %b want 1", bus.valid_out); end
        n_checks++; if (bus.regwrite_out !== 1'b0) begin n_fails++; $display("FAIL st_regwrite_out: got %b want 0", bus.regwrite_out); end
        // load from 0x0005 immediately, no bubble
        idle_inputs();
        bus.valid_in    = 1'b1;
        bus.memread     = 1'b1;
        bus.aluout      = 16'h0005;
        bus.rdin        = 4'd5;
        bus.regwrite_in = 1'b1;
        #1;
        n_checks++; if (bus.stall !== 1'b1) begin n_fails++; $display("FAIL ld_stall_accept: got %b want 1", bus.stall); end
        tick();
        tick();
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fails++; $display("FAIL ld_valid_early: got %b want 0", bus.valid_out); end
        tick();
        idle_inputs();
        n_checks++; if (bus.valid_out !== 1'b1) begin n_fails++; $display("FAIL ld_valid_out: got %b want 1", bus.valid_out); end
        n_checks++; if (bus.wbdata !== 16'hBEEF) begin n_fails++; $display("FAIL ld_wbdata: got %h want beef", bus.wbdata); end
        n_checks++; if (bus.rdout !== 4'd5) begin n_fails++; $display("FAIL ld_rdout: got %0d want 5", bus.rdout); end
        n_checks++; if (bus.regwrite_out !== 1'b1) begin n_fails++; $display("FAIL ld_regwrite_out: got %b want 1", bus.regwrite_out); end
`ifdef MEMORY_CYCLE_FWD_EN
        n_checks++; if (bus.fwd_valid !== 1'b1) begin n_fails++; $display("FAIL fwd_valid: got %b want 1", bus.fwd_valid); end
        n_checks++; if (bus.fwd_rd !== 4'd5) begin n_fails++; $display("FAIL fwd_rd: got %0d want 5", bus.fwd_rd); end
        n_checks++; if (bus.fwd_data !== 16'hBEEF) begin n_fails++; $display("FAIL fwd_data: got %h want beef", bus.fwd_data); end
`else
        n_checks++; if (bus.fwd_valid !== 1'b0) begin n_fails++; $display("FAIL fwd_valid_off: got %b want 0", bus.fwd_valid); end
        n_checks++; if (bus.fwd_rd !== 4'd0) begin n_fails++; $display("FAIL fwd_rd_off: got %0d want 0", bus.fwd_rd); end
`endif
        tick();
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fails++; $display("FAIL ld_valid_drop: got %b want 0", bus.valid_out); end
    endtask

    task automatic test_branch();
        // beq taken
        idle_inputs();
        bus.valid_in = 1'b1;
        bus.branch   = 2'b01;
        bus.zero     = 1'b1;
        bus.newpc    = 16'h0040;
        tick();
        idle_inputs();
        n_checks++; if (bus.flush !== 1'b1) begin n_fails++; $display("FAIL beq_flush: got %b want 1", bus.flush); end
        n_checks++; if (bus.pc_target !== 16'h0040) begin n_fails++; $display("FAIL beq_target: got %h want 0040", bus.pc_target); end
        tick();
        n_checks++; if (bus.flush !== 1'b0) begin n_fails++; $display("FAIL beq_flush_pulse: got %b want 0", bus.flush); end
        // beq not taken
        bus.valid_in = 1'b1;
        bus.branch   = 2'b01;
        bus.zero     = 1'b0;
        bus.pos      = 1'b1;
        bus.newpc    = 16'h0080;
        tick();
        idle_inputs();
        n_checks++; if (bus.flush !== 1'b0) begin n_fails++; $display("FAIL beq_nt_flush: got %b want 0", bus.flush); end
        // bgt taken
        bus.valid_in = 1'b1;
        bus.branch   = 2'b10;
        bus.pos      = 1'b1;
        bus.newpc    = 16'h0090;
        tick();
        idle_inputs();
        n_checks++; if (bus.flush !== 1'b1) begin n_fails++; $display("FAIL bgt_flush: got %b want 1", bus.flush); end
        n_checks++; if (bus.pc_target !== 16'h0090) begin n_fails++; $display("FAIL bgt_target: got %h want 0090", bus.pc_target); end
        // bgt not taken
        bus.valid_in = 1'b1;
        bus.branch   = 2'b10;
        bus.zero     = 1'b1;
        bus.newpc    = 16'h00C0;
        tick();
        idle_inputs();
        n_checks++; if (bus.flush !== 1'b0) begin n_fails++; $display("FAIL bgt_nt_flush: got %b want 0", bus.flush); end
        // jump carrying a store: branch wins, store dropped
        do_store(16'h0007, 16'h0000);
        bus.valid_in  = 1'b1;
        bus.branch    = 2'b11;
        bus.memwrite  = 1'b1;
        bus.aluout    = 16'h0007;
        bus.storedata = 16'h1111;
        bus.newpc     = 16'h00A0;
        #1;
        n_checks++; if (bus.stall !== 1'b0) begin n_fails++; $display("FAIL jmp_store_stall: got %b want 0", bus.stall); end
        tick();
        idle_inputs();
        n_checks++; if (bus.flush !== 1'b1) begin n_fails++; $display("FAIL jmp_flush: got %b want 1", bus.flush); end
        n_checks++; if (bus.pc_target !== 16'h00A0) begin n_fails++; $display("FAIL jmp_target: got %h want 00a0", bus.pc_target); end
        tick();
        do_load(16'h0007, 4'd4);
        n_checks++; if (bus.wbdata !== 16'h0000) begin n_fails++; $display("FAIL jmp_store_dropped: got %h want 0000", bus.wbdata); end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        do_store(16'h0007, 16'h0000);
        bus.valid_in  = 1'b1;
        bus.memwrite  = 1'b1;
        bus.aluout    = 16'h0007;
        bus.storedata = 16'hAAAA;
        tick();
        tick();
        // commit cycle of the store: reset must suppress it
        rst = 1'b1;
        idle_inputs();
        #1;
        n_checks++; if (bus.stall !== 1'b0) begin n_fails++; $display("FAIL rstbusy_stall: got %b want 0", bus.stall); end
        tick();
        rst = 1'b0;
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fails++; $display("FAIL rstbusy_valid_out: got %b want 0", bus.valid_out); end
        tick();
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fails++; $display("FAIL rstbusy_no_late_valid: got %b want 0", bus.valid_out); end
        do_load(16'h0007, 4'd6);
        n_checks++; if (bus.valid_out !== 1'b1) begin n_fails++; $display("FAIL rstbusy_load_valid: got %b want 1", bus.valid_out); end
        n_checks++; if (bus.wbdata !== 16'h0000) begin n_fails++; $display("FAIL rstbusy_load_data: got %h want 0000", bus.wbdata); end
        n_checks++; if (bus.rdout !== 4'd6) begin n_fails++; $display("FAIL rstbusy_load_rd: got %0d want 6", bus.rdout); end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_pass();
        test_back_to_back();
        test_branch();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
